left_shift_pipe: RTL

LEFT_SHIFT_PIPE -- requirements
Module: left_shift_pipe

---
 rtl/shift_pkg.sv | 14 +
 rtl/lshift_stage.sv | 58 +++++
 rtl/left_shift_pipe.sv | 83 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the left shift/rotate pipeline: default width,
// shift-count width derivation and the rotate-mode encoding.
package shift_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic MODE_LSL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

  function automatic int shw(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/lshift_stage.sv
// One registered stage of the shift/rotate pipeline: moves the word left by
// DIST positions when its shift bit is set, then registers word, count, mode, valid.
module lshift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DIST     = 1,
  parameter bit RST_DATA = 1'b0,
  localparam int SHW     = shw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shin,
  input  logic             rin,
  output logic             vq,
  output logic [WIDTH-1:0] dq,
  output logic [SHW-1:0]   shq,
  output logic             rq
);

  localparam int BIT = shw(DIST);

  logic [WIDTH-1:0] moved, nxt;
  logic             load;

  assign moved = (rin == MODE_ROL) ? ((din << DIST) | (din >> (WIDTH - DIST)))
                                   : (din << DIST);
  assign nxt   = shin[BIT] ? moved : din;
  // Payload only moves with a real word, so bubbles never disturb a held result.
  assign load  = en && vin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vq <= 1'b0;
    else if (en) vq <= vin;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shq <= shin;
      rq  <= rin;
    end
  end

  if (RST_DATA) begin : g_rst_data
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       dq <= '0;
      else if (load) dq <= nxt;
    end
  end else begin : g_nrst_data
    always_ff @(posedge clk) begin
      if (load) dq <= nxt;
    end
  end

endmodule

// File: rtl/left_shift_pipe.sv
// SHW-stage pipelined logical-shift / rotate-left unit with a global stall enable.
// Optional registered zero flag on the result when LSHIFT_ZERO_FLAG_EN is defined.
module left_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int SHW  = shw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [SHW-1:0]   shift,
  input  logic             rotate,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LSHIFT_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] y
);

  logic [SHW:0]            vld_pipe;
  logic [SHW:0][WIDTH-1:0] d_pipe;
  logic [SHW:0][SHW-1:0]   sh_pipe;
  logic [SHW:0]            rot_pipe;
  logic                    en;

  // Count and mode are dead once the last stage has applied its move.
  logic [SHW-1:0]          sh_unused;
  logic                    rot_unused;

  assign en          = !out_valid || out_ready;
  assign in_ready    = en;

  assign vld_pipe[0] = in_valid;
  assign d_pipe[0]   = x;
  assign sh_pipe[0]  = shift;
  assign rot_pipe[0] = rotate;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    lshift_stage #(
      .WIDTH    (WIDTH),
      .DIST     (1 << k),
      .RST_DATA (k == SHW - 1)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .vin  (vld_pipe[k]),
      .din  (d_pipe[k]),
      .shin (sh_pipe[k]),
      .rin  (rot_pipe[k]),
      .vq   (vld_pipe[k+1]),
      .dq   (d_pipe[k+1]),
      .shq  (sh_pipe[k+1]),
      .rq   (rot_pipe[k+1])
    );
  end

  assign out_valid  = vld_pipe[SHW];
  assign y          = d_pipe[SHW];
  assign sh_unused  = sh_pipe[SHW];
  assign rot_unused = rot_pipe[SHW];

`ifdef LSHIFT_ZERO_FLAG_EN
  // Last stage moves by WIDTH/2; predict its result so the flag lands with y.
  localparam int LD = WIDTH / 2;

  logic [WIDTH-1:0] lin, lmv, lnxt;

  assign lin  = d_pipe[SHW-1];
  assign lmv  = (rot_pipe[SHW-1] == MODE_ROL) ? ((lin << LD) | (lin >> LD)) : (lin << LD);
  assign lnxt = sh_pipe[SHW-1][SHW-1] ? lmv : lin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          zero <= 1'b1;
    else if (en && vld_pipe[SHW-1])   zero <= ~|lnxt;
  end
`endif

endmodule
